// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the five-stage RV64 core.
// Holds on stall, inserts an all-zero bubble on flush, and gates side-effecting controls with id_valid.
module id_ex_reg #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,

  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [6:0]      id_funct7,
  input  logic [2:0]      id_funct3,
  input  logic [1:0]      id_aluOp,
  input  logic            id_aluSrc,
  input  logic            id_memRead,
  input  logic            id_memWrite,
  input  logic            id_regWrite,
  input  logic            id_memToReg,
  input  logic            id_branch,

  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_funct7,
  output logic [2:0]      ex_funct3,
  output logic [1:0]      ex_aluOp,
  output logic            ex_aluSrc,
  output logic            ex_memRead,
  output logic            ex_memWrite,
  output logic            ex_regWrite,
  output logic            ex_memToReg,
  output logic            ex_branch
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [1:0]      aluOp;
    logic            aluSrc;
    logic            memRead;
    logic            memWrite;
    logic            regWrite;
    logic            memToReg;
    logic            branch;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;
  stage_t idStage;

  // Side-effecting controls are masked by id_valid so ex_valid = 0 always implies no writes or branch.
  always_comb begin
    idStage          = '0;
    idStage.valid    = id_valid;
    idStage.pc       = id_pc;
    idStage.rs1Data  = id_rs1_data;
    idStage.rs2Data  = id_rs2_data;
    idStage.imm      = id_imm;
    idStage.rs1      = id_rs1;
    idStage.rs2      = id_rs2;
    idStage.rd       = id_rd;
    idStage.funct7   = id_funct7;
    idStage.funct3   = id_funct3;
    idStage.aluOp    = id_aluOp;
    idStage.aluSrc   = id_aluSrc;
    idStage.memRead  = id_memRead  & id_valid;
    idStage.memWrite = id_memWrite & id_valid;
    idStage.regWrite = id_regWrite & id_valid;
    idStage.memToReg = id_memToReg;
    idStage.branch   = id_branch   & id_valid;
  end

  // Flush outranks stall: a killed instruction must not linger while the hazard unit holds ID.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d = idStage;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ex_valid    = stage_q.valid;
  assign ex_pc       = stage_q.pc;
  assign ex_rs1_data = stage_q.rs1Data;
  assign ex_rs2_data = stage_q.rs2Data;
  assign ex_imm      = stage_q.imm;
  assign ex_rs1      = stage_q.rs1;
  assign ex_rs2      = stage_q.rs2;
  assign ex_rd       = stage_q.rd;
  assign ex_funct7   = stage_q.funct7;
  assign ex_funct3   = stage_q.funct3;
  assign ex_aluOp    = stage_q.aluOp;
  assign ex_aluSrc   = stage_q.aluSrc;
  assign ex_memRead  = stage_q.memRead;
  assign ex_memWrite = stage_q.memWrite;
  assign ex_regWrite = stage_q.regWrite;
  assign ex_memToReg = stage_q.memToReg;
  assign ex_branch   = stage_q.branch;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: table-driven directed vectors, a reset-mid-stall sequence
// and a randomized run, all checked through a scoreboard queue fed by a reference model.
module tb_id_ex_reg;

  localparam int XLEN = 64;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [1:0]      aluOp;
    logic            aluSrc;
    logic            memRead;
    logic            memWrite;
    logic            regWrite;
    logic            memToReg;
    logic            branch;
  } bundle_t;

  typedef struct {
    string           name;
    logic            rst;
    logic            stall;
    logic            flush;
    bundle_t         in;
    logic [XLEN-1:0] expPc;
    logic [4:0]      expRd;
    logic            expValid;
    logic            expRegWrite;
  } vec_t;

  typedef struct {
    string   name;
    bundle_t exp;
  } sb_t;

  logic    clk = 1'b0;
  logic    rst, stall, flush;
  bundle_t drv;
  bundle_t act;
  bundle_t modelQ;
  sb_t     sbQueue[$];
  int      checks = 0;
  int      errors = 0;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [6:0]      ex_funct7;
  logic [2:0]      ex_funct3;
  logic [1:0]      ex_aluOp;
  logic            ex_aluSrc, ex_memRead, ex_memWrite, ex_regWrite, ex_memToReg, ex_branch;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(drv.valid), .id_pc(drv.pc), .id_rs1_data(drv.rs1Data), .id_rs2_data(drv.rs2Data),
    .id_imm(drv.imm), .id_rs1(drv.rs1), .id_rs2(drv.rs2), .id_rd(drv.rd),
    .id_funct7(drv.funct7), .id_funct3(drv.funct3), .id_aluOp(drv.aluOp), .id_aluSrc(drv.aluSrc),
    .id_memRead(drv.memRead), .id_memWrite(drv.memWrite), .id_regWrite(drv.regWrite),
    .id_memToReg(drv.memToReg), .id_branch(drv.branch),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct7(ex_funct7), .ex_funct3(ex_funct3), .ex_aluOp(ex_aluOp), .ex_aluSrc(ex_aluSrc),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_regWrite(ex_regWrite),
    .ex_memToReg(ex_memToReg), .ex_branch(ex_branch)
  );

  assign act = '{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                 ex_funct7, ex_funct3, ex_aluOp, ex_aluSrc, ex_memRead, ex_memWrite,
                 ex_regWrite, ex_memToReg, ex_branch};

  // Downstream ALU control as EX would decode it.
  function automatic logic [3:0] aluCtl(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    logic [3:0] r;
    r = ALU_ADD;
    if (op == 2'b01) r = ALU_SUB;
    else if (op == 2'b10) begin
      case (f3)
        3'b000:  r = f7[5] ? ALU_SUB : ALU_ADD;
        3'b111:  r = ALU_AND;
        3'b110:  r = ALU_OR;
        default: r = ALU_ADD;
      endcase
    end
    return r;
  endfunction

  function automatic bundle_t gateInvalid(input bundle_t b);
    bundle_t g;
    g = b;
    if (!b.valid) begin
      g.regWrite = 1'b0;
      g.memRead  = 1'b0;
      g.memWrite = 1'b0;
      g.branch   = 1'b0;
    end
    return g;
  endfunction

  function automatic bundle_t randBundle();
    bundle_t b;
    b.valid    = 1'($urandom_range(0, 3) != 0);
    b.pc       = {$urandom, $urandom};
    b.rs1Data  = {$urandom, $urandom};
    b.rs2Data  = {$urandom, $urandom};
    b.imm      = {$urandom, $urandom};
    b.rs1      = 5'($urandom);
    b.rs2      = 5'($urandom);
    b.rd       = 5'($urandom);
    b.funct7   = 7'($urandom);
    b.funct3   = 3'($urandom);
    b.aluOp    = 2'($urandom);
    b.aluSrc   = 1'($urandom);
    b.memRead  = 1'($urandom);
    b.memWrite = 1'($urandom);
    b.regWrite = 1'($urandom);
    b.memToReg = 1'($urandom);
    b.branch   = 1'($urandom);
    return b;
  endfunction

  function automatic void check(input string name, input logic [511:0] actV, input logic [511:0] expV);
    checks++;
    if (actV !== expV) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actV, expV);
    end
  endfunction

  // Drive one cycle of stimulus; the reference model's next state goes to the scoreboard.
  task automatic applyStimulus(input string name, input logic r, input logic s, input logic f, input bundle_t in);
    sb_t e;
    rst   = r;
    stall = s;
    flush = f;
    drv   = in;
    if (r || f) modelQ = '0;
    else if (!s) modelQ = gateInvalid(in);
    e.name = name;
    e.exp  = modelQ;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard after the edge, then confirm the outputs stay put until the next edge.
  task automatic checkOutput();
    sb_t     e;
    bundle_t snap;
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: queue empty, got 0 expected 1 entry");
      return;
    end
    e = sbQueue.pop_front();
    check(e.name, 512'(act), 512'(e.exp));
    snap = act;
    @(negedge clk);
    check({e.name, "_stable"}, 512'(act), 512'(snap));
  endtask

  vec_t    tbl[12];
  bundle_t nz, instA, instB, inv;

  function automatic vec_t mkVec(input string n, input logic r, input logic s, input logic f, input bundle_t in,
                                 input logic [XLEN-1:0] pc, input logic [4:0] rd, input logic v, input logic rw);
    vec_t t;
    t.name = n; t.rst = r; t.stall = s; t.flush = f; t.in = in;
    t.expPc = pc; t.expRd = rd; t.expValid = v; t.expRegWrite = rw;
    return t;
  endfunction

  initial begin
    nz = '{1'b1, 64'h100, 64'h1111, 64'h2222, 64'h3333, 5'd1, 5'd2, 5'd3, 7'h7f, 3'h7, 2'b10,
           1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    instA = '{1'b1, 64'h40, 64'hA1, 64'hA2, 64'h8, 5'd3, 5'd4, 5'd5, 7'b0100000, 3'b000, 2'b10,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    instB = '{1'b1, 64'h44, 64'hB1, 64'hB2, 64'hFFFF_FFFF_FFFF_FFF0, 5'd7, 5'd8, 5'd6, 7'b0000000,
              3'b010, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    inv = '{1'b0, 64'h80, 64'hC1, 64'hC2, 64'h10, 5'd9, 5'd10, 5'd7, 7'h0, 3'h0, 2'b01,
            1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    tbl[0]  = mkVec("reset1",     1, 0, 0, nz,    64'h0,  5'd0, 0, 0);
    tbl[1]  = mkVec("reset2",     1, 0, 0, nz,    64'h0,  5'd0, 0, 0);
    tbl[2]  = mkVec("loadA",      0, 0, 0, instA, 64'h40, 5'd5, 1, 1);
    tbl[3]  = mkVec("stall1",     0, 1, 0, instB, 64'h40, 5'd5, 1, 1);
    tbl[4]  = mkVec("stall2",     0, 1, 0, instB, 64'h40, 5'd5, 1, 1);
    tbl[5]  = mkVec("stall3",     0, 1, 0, instB, 64'h40, 5'd5, 1, 1);
    tbl[6]  = mkVec("release",    0, 0, 0, instB, 64'h44, 5'd6, 1, 1);
    tbl[7]  = mkVec("reloadA",    0, 0, 0, instA, 64'h40, 5'd5, 1, 1);
    tbl[8]  = mkVec("flush",      0, 0, 1, instA, 64'h0,  5'd0, 0, 0);
    tbl[9]  = mkVec("reloadA2",   0, 0, 0, instA, 64'h40, 5'd5, 1, 1);
    tbl[10] = mkVec("stallFlush", 0, 1, 1, instA, 64'h0,  5'd0, 0, 0);
    tbl[11] = mkVec("invalid",    0, 0, 0, inv,   64'h80, 5'd7, 0, 0);

    modelQ = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; drv = nz;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].name, tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].in);
      check({tbl[i].name, "_pc"},       512'(ex_pc),       512'(tbl[i].expPc));
      check({tbl[i].name, "_rd"},       512'(ex_rd),       512'(tbl[i].expRd));
      check({tbl[i].name, "_valid"},    512'(ex_valid),    512'(tbl[i].expValid));
      check({tbl[i].name, "_regWrite"}, 512'(ex_regWrite), 512'(tbl[i].expRegWrite));
      if (tbl[i].name == "loadA")
        check("loadA_aluCtl", 512'(aluCtl(ex_aluOp, ex_funct7, ex_funct3)), 512'(ALU_SUB));
      if (tbl[i].name == "invalid")
        check("invalid_memWrite", 512'(ex_memWrite), 512'(1'b0));
      checkOutput();
    end

    // Reset while stalled clears everything; the following edge loads what ID presents.
    applyStimulus("midStall_loadA", 0, 0, 0, instA); checkOutput();
    applyStimulus("midStall_hold",  0, 1, 0, instB); checkOutput();
    applyStimulus("midStall_rst",   1, 1, 0, instB); checkOutput();
    check("midStall_rst_pc", 512'(ex_pc), 512'(64'h0));
    applyStimulus("midStall_after", 0, 0, 0, instB); checkOutput();
    check("midStall_after_pc", 512'(ex_pc), 512'(64'h44));

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      applyStimulus($sformatf("rand%0d", i), 1'(sel == 0), 1'(sel >= 6), 1'(sel == 5 || sel == 9), randBundle());
      checkOutput();
      if (!ex_valid)
        check($sformatf("rand%0d_bubbleInv", i),
              512'({ex_regWrite, ex_memRead, ex_memWrite, ex_branch}), 512'(4'b0000));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between the ID and EX stages of the five-stage RV64 core. Captures decoded instruction fields, register-file read data, immediate and control signals every cycle. Presents them to EX: ALU control, ALU, forwarding muxes and branch compare. Supports stall (hold contents) and flush (insert a bubble) for the hazard unit and branch resolution.

## Interface
- XLEN, 64, datapath width (PC, operands, immediate)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all registered contents this cycle
- flush  in  1  replace contents with a bubble this cycle
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read values
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register addresses
- id_funct7  in  7  instruction bits 31:25
- id_funct3  in  3  instruction bits 14:12
- id_aluOp  in  2  00 add (ld/sd), 01 sub (beq), 10 R-type decode
- id_aluSrc  in  1  ALU operand B: 0 = rs2_data, 1 = imm
- id_memRead, id_memWrite, id_regWrite, id_memToReg, id_branch  in  1 each  control signals
- ex_*  out  same widths  registered copies of every id_* input above, including ex_valid

## Operation
- All ex_* outputs are registered.
- No combinational path exists from any input to any output.
- Per-cycle update, evaluated at rising clk, with this priority:
  - rst = 1: every ex_* output becomes 0.
  - flush = 1: every ex_* output becomes 0, producing a bubble. Flush wins over stall.
  - stall = 1 (flush = 0): every ex_* output keeps its current value.
  - Otherwise: every ex_* output loads its id_* input.
- The bubble encoding is all-zero:
  - ex_valid = 0, ex_regWrite = 0, ex_memWrite = 0, ex_memRead = 0, ex_branch = 0.
  - ex_aluOp = 00, so ALU control yields add.
  - ex_rd = 0, so forwarding never matches a real register.
- Bubble invariant: whenever ex_valid = 0, ex_regWrite, ex_memRead, ex_memWrite and ex_branch are 0.
  - The bubble path enforces this by construction.
  - On the load path, the register gates these four controls with id_valid.
- Data fields (pc, rs data, imm, funct fields, addresses) are loaded unchanged, even when id_valid = 0.
- Stall and flush are level signals sampled each cycle. Multi-cycle stall holds indefinitely.
- The block does not inspect funct7 or funct3. Decoding is done downstream.

## Timing
- Latency: 1 cycle. An id_* value present before edge N appears on ex_* after edge N.
- Throughput: 1 instruction per cycle when stall = 0.
- Reset is synchronous. rst asserted mid-stall or mid-flush clears everything at the next edge.
- After rst deasserts, normal loading resumes on the next edge.
- Simultaneous stall and flush: the bubble is inserted and the ID contents are dropped.
  - Re-presenting the dropped instruction is the upstream stage's responsibility.
- Stall release: the first edge with stall = 0 loads the id_* values then present.
- No output changes between clock edges.

## Test plan
- Reset: drive every id_* to nonzero (id_pc = 0x100, id_aluOp = 10, id_regWrite = 1) with rst = 1 for 2 edges.
  - Every ex_* is 0 after the first edge.
- Load: rst = 0, id_valid = 1, id_pc = 0x40, id_funct7 = 0100000, id_funct3 = 000, id_aluOp = 10, id_rd = 5, id_regWrite = 1.
  - One edge later ex_* matches exactly, and the downstream ALU control decodes sub.
- Stall: load instruction A (id_pc = 0x40), then assert stall for 3 edges while presenting instruction B (id_pc = 0x44).
  - ex_pc stays 0x40 throughout.
  - On the first edge after stall drops, ex_pc = 0x44.
- Flush and flush-beats-stall:
  - With A loaded, flush = 1: after one edge, all ex_* are 0.
  - Repeat with stall = 1 and flush = 1 together: same all-zero result.
- Invalid gating: id_valid = 0 with id_regWrite = 1, id_memWrite = 1, id_rd = 7.
  - After one edge, ex_valid = 0, ex_regWrite = 0, ex_memWrite = 0, ex_rd = 7.
- Reset mid-stall: stall = 1 holding A, then rst = 1 for one edge.
  - All ex_* are 0.
  - With rst = 0 and stall = 0, the next edge loads the current id_* values.
